// File: rtl/mix_unmix.sv
// Iterative 8-word mixer: one 32-bit word update per cycle, ROUNDS rounds of
// add-chain then shift-xor (encode), or the exact reverse sequence (decode).
module mix_unmix #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  logic [1:0]  state;
  logic [31:0] w [8];
  logic        mode;
  logic [2:0]  idx;
  logic        phase;
  logic [3:0]  round;

  logic [2:0]  sel;
  logic [2:0]  sel_prev;
  logic [2:0]  sel_rot;
  logic [31:0] cur_w;
  logic [31:0] prev_w;
  logic [31:0] rot_w;
  logic [31:0] next_w;
  logic        add_step;
  logic        last_op;

  // Decode walks the words 7..0 (~idx); add-type steps are encode phase 0
  // and decode phase 1, so mode ^ phase picks the add/subtract step.
  always_comb begin
    sel      = mode ? idx : ~idx;
    sel_prev = sel + 3'd7;
    sel_rot  = sel + 3'd3;
    cur_w    = w[sel];
    prev_w   = w[sel_prev];
    rot_w    = w[sel_rot];
    add_step = mode ^ phase;
    next_w   = cur_w ^ (rot_w << 16);
    if (add_step) begin
      next_w = mode ? (cur_w + prev_w) : (cur_w - prev_w);
    end
    last_op  = phase && (idx == 3'd7) && (round == LAST_ROUND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= 1'b0;
      idx   <= 3'd0;
      phase <= 1'b0;
      round <= 4'd0;
      for (int k = 0; k < 8; k++) begin
        w[k] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 8; k++) begin
              w[k] <= in_data[32*k +: 32];
            end
            mode  <= in_mode;
            idx   <= 3'd0;
            phase <= 1'b0;
            round <= 4'd0;
            state <= RUN;
          end
        end
        RUN: begin
          w[sel] <= next_w;
          idx    <= idx + 3'd1;
          if (idx == 3'd7) begin
            phase <= ~phase;
            if (phase) begin
              round <= round + 4'd1;
            end
          end
          if (last_op) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      out_data[32*k +: 32] = w[k];
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

endmodule

// File: doc/mix_unmix.md
MIX_UNMIX -- requirements
Module: mix_unmix

Interface
REQ-001 SHALL have parameter ROUNDS, default 4, number of mix rounds applied per block; legal range 1..15.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input block offered.
REQ-005 SHALL have port in_ready  output  1  block may be accepted.
REQ-006 SHALL have port in_data  input  256  eight 32-bit words; word i = bits [32i+31:32i].
REQ-007 SHALL have port in_mode  input  1  1 = encode (forward mix), 0 = decode (inverse mix).
REQ-008 SHALL have port out_valid  output  1  result block available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_data  output  256  result words, same packing as in_data.
REQ-011 SHALL have port busy  output  1  high while state is RUN.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE); busy = (state == RUN).
REQ-013 SHALL accept a block on a rising edge with in_valid && in_ready: latch in_data into working words w0..w7, latch in_mode, clear op counters, go to RUN.
REQ-014 SHALL perform exactly one word update per cycle in RUN, using current (already updated) values of all words.
REQ-015 SHALL define forward step A as i = 0..7 in order: w[i] = w[i] + w[(i+7) mod 8], modulo 2^32.
REQ-016 SHALL define forward step B as i = 0..7 in order: w[i] = w[i] ^ (w[(i+3) mod 8] << 16), shift within 32 bits, upper bits discarded.
REQ-017 SHALL, in encode mode, run ROUNDS rounds, each = step A (8 cycles) then step B (8 cycles).
REQ-018 SHALL, in decode mode, run ROUNDS rounds, each = inverse B (i = 7..0: w[i] ^= w[(i+3) mod 8] << 16) then inverse A (i = 7..0: w[i] = w[i] - w[(i+7) mod 8], modulo 2^32).
REQ-019 SHALL make decode(encode(x)) == x bit-exact for every x and equal ROUNDS.
REQ-020 SHALL take exactly 16*ROUNDS RUN cycles; out_valid rises on the edge executing the final update, i.e. 16*ROUNDS cycles after the accept edge.
REQ-021 SHALL drive out_data = w0..w7 continuously; in DONE it holds stable until out_valid && out_ready, then state goes IDLE.
REQ-022 SHALL ignore in_valid, in_data, in_mode while in RUN or DONE; no input buffering, no overlap.
REQ-023 SHALL allow a new accept no earlier than the cycle after the output handshake (in_ready rises on that edge).
REQ-024 SHALL wrap the word index 7->0 and the step/round counters without glitch; round counter width >= 4 bits.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state IDLE, all w words 0, counters 0, mode 0; thus in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-026 SHALL abort any block in RUN or DONE when rst_n asserts; the aborted block is never output.
REQ-027 SHALL resume normal acceptance on the first rising edge after rst_n deasserts.

Verification
REQ-028 ROUNDS=1, encode, in_data words {0,1,2,3,4,5,6,7} -> after 16 cycles out words {0x000D0007,0x00110008,0x0016000A,0x001C000D,0x00230011,0x00070016,0x0008001C,0x000A0023}.
REQ-029 ROUNDS=1, decode of the REQ-028 output -> {0,1,2,3,4,5,6,7}; encode of all-zeros -> all-zeros.
REQ-030 ROUNDS=4, 1000 random blocks, encode then decode each -> output equals original; out_valid exactly 64 cycles after each accept.
REQ-031 out_ready held low 20 cycles in DONE -> out_data stable, in_ready 0, new in_valid ignored; out_ready high -> in_ready 1 next cycle.
REQ-032 rst_n pulsed low mid-RUN (cycle 7 of block) -> outputs immediately zero/idle, no out_valid; next block processes correctly.
